// File: rtl/spi_master_arb.sv
// spi_master_arb: two-requester, round-robin SPI master for 8-bit frames, MSB first.
// Optional receive path enabled by defining SPI_MISO_EN (adds miso / rx_data ports).
module spi_master_arb #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       grant_id,
  output logic       done
`ifdef SPI_MISO_EN
  ,
  input  logic       miso,
  output logic [7:0] rx_data
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             done_q, done_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [7:0]       load_byte;
`ifdef SPI_MISO_EN
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
`endif

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign done     = done_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);
`ifdef SPI_MISO_EN
  assign rx_data  = rx_data_q;
`endif

  // Round-robin ready: lone requester wins, tie goes to the one not served last.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant_q;
        req1_ready = !last_grant_q;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    shift_d      = shift_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    cs_n_d       = cs_n_q;
    done_d       = 1'b0;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    load_byte    = req1_ready ? req1_data : req0_data;
`ifdef SPI_MISO_EN
    rx_sh_d      = rx_sh_q;
    rx_data_d    = rx_data_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          shift_d      = load_byte;
          mosi_d       = load_byte[7];
          grant_d      = req1_ready;
          last_grant_d = req1_ready;
          bit_cnt_d    = '0;
          div_cnt_d    = '0;
          cs_n_d       = 1'b0;
          state_d      = S_LOW;
        end
      end
      S_LOW: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          state_d   = S_HIGH;
`ifdef SPI_MISO_EN
          rx_sh_d   = {rx_sh_q[6:0], miso};
`endif
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            cs_n_d    = 1'b1;
            done_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = S_GAP;
`ifdef SPI_MISO_EN
            rx_data_d = rx_sh_q;
`endif
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            mosi_d    = shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = S_LOW;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      shift_q      <= '0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      done_q       <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef SPI_MISO_EN
      rx_sh_q      <= '0;
      rx_data_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shift_q      <= shift_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
      done_q       <= done_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
`ifdef SPI_MISO_EN
      rx_sh_q      <= rx_sh_d;
      rx_data_q    <= rx_data_d;
`endif
    end
  end

endmodule
